// File: rtl/ret_stack_if.sv
// Request/status bundle for the return-address stack. The core drives requests
// and reads status through the master side; the stack uses the slave side.
interface ret_stack_if #(
  parameter int NBITS = 9,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH+1);

  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [NBITS-1:0] in;
  logic [NBITS-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (output push, pop, flush, err_clr, in,
                  input  top, count, empty, full, ovf, unf);
  modport slave  (input  push, pop, flush, err_clr, in,
                  output top, count, empty, full, ovf, unf);
endinterface

// File: rtl/ret_stack.sv
// Return-address stack: top held in a register for zero-latency RET, the
// remaining DEPTH-1 entries in a circular body indexed by a wrapping pointer.
module ret_stack #(
  parameter int NBITS = 9,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0
) (
  input logic       clk,
  input logic       rst,
  ret_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH-2);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [NBITS-1:0] body [DEPTH-1];
  logic [NBITS-1:0] top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic             empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;
  logic             we;

  // ptr_q is the next free body slot; once the body is full it is also the oldest
  assign ptr_inc = (ptr_q == PMAX) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PMAX : ptr_q - 1'b1;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q & ~bus.err_clr;
    unf_d   = unf_q & ~bus.err_clr;
    we      = 1'b0;
    if (bus.flush) begin
      top_d   = '0;
      count_d = '0;
    end else if (bus.push && bus.pop) begin
      top_d = bus.in;
      if (empty_q) begin
        unf_d   = 1'b1;
        count_d = CW'(1);
      end
    end else if (bus.push) begin
      if (!full_q) begin
        top_d   = bus.in;
        count_d = count_q + 1'b1;
        if (!empty_q) begin
          we    = 1'b1;
          ptr_d = ptr_inc;
        end
      end else begin
        ovf_d = 1'b1;
        if (WRAP != 0) begin
          top_d = bus.in;
          we    = 1'b1;
          ptr_d = ptr_inc;
        end
      end
    end else if (bus.pop) begin
      if (empty_q) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          top_d = '0;
        end else begin
          top_d = body[ptr_dec];
          ptr_d = ptr_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CMAX);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) body[ptr_q] <= top_q;
  end

  assign bus.top   = top_q;
  assign bus.count = count_q;
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_ret_stack.sv
// Directed bench: a saturating (a) and a wrapping (b) stack, DEPTH=4, NBITS=9,
// driven with identical stimulus and checked against hand-computed values.
module tb_ret_stack;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ret_stack_if #(.NBITS(9), .DEPTH(4)) ia ();
  ret_stack_if #(.NBITS(9), .DEPTH(4)) ib ();

  ret_stack #(.NBITS(9), .DEPTH(4), .WRAP(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  ret_stack #(.NBITS(9), .DEPTH(4), .WRAP(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle with the given request on both stacks, then sample after the edge
  task automatic step(input logic p, input logic q, input logic f, input logic c,
                      input logic [8:0] d, input logic r);
    rst = r;
    ia.push = p; ia.pop = q; ia.flush = f; ia.err_clr = c; ia.in = d;
    ib.push = p; ib.pop = q; ib.flush = f; ib.err_clr = c; ib.in = d;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ia.push = 0; ia.pop = 0; ia.flush = 0; ia.err_clr = 0; ia.in = '0;
    ib.push = 0; ib.pop = 0; ib.flush = 0; ib.err_clr = 0; ib.in = '0;
  endtask

  task automatic push(input logic [8:0] d); step(1, 0, 0, 0, d, 0); endtask
  task automatic pop();                     step(0, 1, 0, 0, '0, 0); endtask

  initial begin
    rst = 1'b1;
    ia.push = 0; ia.pop = 0; ia.flush = 0; ia.err_clr = 0; ia.in = '0;
    ib.push = 0; ib.pop = 0; ib.flush = 0; ib.err_clr = 0; ib.in = '0;
    step(0, 0, 0, 0, '0, 1);
    chk("rst.top",   ia.top, 0);
    chk("rst.count", ia.count, 0);
    chk("rst.empty", ia.empty, 1);
    chk("rst.full",  ia.full, 0);
    chk("rst.ovf",   ia.ovf, 0);
    chk("rst.unf",   ia.unf, 0);
    chk("rst.b.empty", ib.empty, 1);

    // basic LIFO
    push(9'h011); push(9'h022); push(9'h033);
    chk("t1.top3",   ia.top, 9'h033);
    chk("t1.count3", ia.count, 3);
    pop();
    chk("t1.top2",   ia.top, 9'h022);
    chk("t1.count2", ia.count, 2);
    pop(); pop();
    chk("t1.empty",  ia.empty, 1);
    chk("t1.top0",   ia.top, 0);

    // full, then push while full: a saturates, b discards oldest
    push(9'h001); push(9'h002); push(9'h003); push(9'h004);
    chk("t2.full",   ia.full, 1);
    chk("t2.count",  ia.count, 4);
    push(9'h1FF);
    chk("t2.a.ovf",   ia.ovf, 1);
    chk("t2.a.top",   ia.top, 9'h004);
    chk("t2.a.count", ia.count, 4);
    chk("t3.b.ovf",   ib.ovf, 1);
    chk("t3.b.top",   ib.top, 9'h1FF);
    chk("t3.b.count", ib.count, 4);
    pop();
    chk("t2.a.pop1", ia.top, 9'h003);
    chk("t3.b.pop1", ib.top, 9'h004);
    pop();
    chk("t2.a.pop2", ia.top, 9'h002);
    chk("t3.b.pop2", ib.top, 9'h003);
    pop();
    chk("t2.a.pop3", ia.top, 9'h001);
    chk("t3.b.pop3", ib.top, 9'h002);
    pop();
    chk("t2.a.empty", ia.empty, 1);
    chk("t3.b.empty", ib.empty, 1);
    chk("t3.b.count", ib.count, 0);
    chk("t3.b.unf",   ib.unf, 0);
    step(0, 0, 0, 1, '0, 0);
    chk("clr.ovf", ia.ovf, 0);

    // underflow flag behaviour
    pop();
    chk("t4.unf",   ia.unf, 1);
    chk("t4.count", ia.count, 0);
    chk("t4.top",   ia.top, 0);
    pop();
    chk("t4.rep.count", ia.count, 0);
    chk("t4.rep.top",   ia.top, 0);
    step(0, 0, 0, 1, '0, 0);
    chk("t4.clr", ia.unf, 0);
    step(0, 1, 0, 1, '0, 0);
    chk("t4.setwins", ia.unf, 1);
    step(0, 0, 0, 1, '0, 0);

    // push&pop replaces top
    push(9'h0A0); push(9'h0B0);
    step(1, 1, 0, 0, 9'h0C0, 0);
    chk("t5.rep.top",   ia.top, 9'h0C0);
    chk("t5.rep.count", ia.count, 2);
    chk("t5.rep.unf",   ia.unf, 0);
    pop();
    chk("t5.pop.top", ia.top, 9'h0A0);
    pop();
    step(1, 1, 0, 0, 9'h055, 0);
    chk("t5.pe.unf",   ia.unf, 1);
    chk("t5.pe.top",   ia.top, 9'h055);
    chk("t5.pe.count", ia.count, 1);

    // flush beats push, flags kept
    push(9'h066); push(9'h067);
    chk("t6.count3", ia.count, 3);
    step(1, 0, 1, 0, 9'h077, 0);
    chk("t6.fl.count", ia.count, 0);
    chk("t6.fl.empty", ia.empty, 1);
    chk("t6.fl.top",   ia.top, 0);
    chk("t6.fl.unf",   ia.unf, 1);

    // push&pop while full: replace, no overflow
    push(9'h101); push(9'h102); push(9'h103); push(9'h104);
    step(1, 1, 0, 0, 9'h1AA, 0);
    chk("pp.full.top",   ia.top, 9'h1AA);
    chk("pp.full.count", ia.count, 4);
    chk("pp.full.ovf",   ia.ovf, 0);
    pop();
    chk("pp.full.next", ia.top, 9'h103);

    // reset beats push
    step(1, 0, 0, 0, 9'h123, 1);
    chk("t6.rst.top",   ia.top, 0);
    chk("t6.rst.count", ia.count, 0);
    chk("t6.rst.empty", ia.empty, 1);
    chk("t6.rst.unf",   ia.unf, 0);
    chk("t6.rst.b.top", ib.top, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
